// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Multicycle signed restoring divider for the DIV instruction. The control
//   unit pulses start. The quotient goes to Lo and the remainder goes to Hi.
//   A zero divisor raises div_zero, which the control unit turns into an
//   exception.
//
//   Ports:
//     clk       in   system clock, rising-edge
//     reset     in   synchronous active-high reset, overrides everything
//     start     in   one-cycle request, only looked at while idle
//     dividend  in   WIDTH  signed dividend (A-side operand mux)
//     divisor   in   WIDTH  signed divisor  (B-side operand mux)
//     busy      out  high while CALC/FIX
//     done      out  one-cycle pulse, hi/lo/div_zero final
//     div_zero  out  sticky: last accepted start had a zero divisor
//     hi        out  WIDTH  remainder (takes the sign of the dividend)
//     lo        out  WIDTH  quotient (truncated toward zero)
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t           state_q;
    logic             busy_q;
    logic             done_q;
    logic             div_zero_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] dvs_q;
    logic             sign_q_q;
    logic             sign_r_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quot_d;

    // Operand magnitudes. The most negative value maps to 2^(WIDTH-1) as unsigned.
    always_comb begin
        dividend_mag = dividend[WIDTH-1] ? ({WIDTH{1'b0}} - dividend) : dividend;
        divisor_mag  = divisor[WIDTH-1]  ? ({WIDTH{1'b0}} - divisor)  : divisor;
    end

    // One restoring step. The shifted remainder needs WIDTH+1 bits for the
    // trial subtraction. After the step, the kept value is always below the
    // divisor, so WIDTH bits are enough to store it.
    always_comb begin
        rem_sh = {rem_q, quot_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvs_q};
        if (trial[WIDTH] == 1'b0) begin
            rem_d  = trial[WIDTH-1:0];
            quot_d = {quot_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d  = rem_sh[WIDTH-1:0];
            quot_d = {quot_q[WIDTH-2:0], 1'b0};
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= {WIDTH{1'b0}};
            lo_q       <= {WIDTH{1'b0}};
            rem_q      <= {WIDTH{1'b0}};
            quot_q     <= {WIDTH{1'b0}};
            dvs_q      <= {WIDTH{1'b0}};
            sign_q_q   <= 1'b0;
            sign_r_q   <= 1'b0;
            cnt_q      <= {CW{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    if (start) begin
                        if (divisor == {WIDTH{1'b0}}) begin
                            // Report immediately. The previous hi/lo results are kept.
                            div_zero_q <= 1'b1;
                            done_q     <= 1'b1;
                        end else begin
                            div_zero_q <= 1'b0;
                            done_q     <= 1'b0;
                            quot_q     <= dividend_mag;
                            dvs_q      <= divisor_mag;
                            sign_q_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            sign_r_q   <= dividend[WIDTH-1];
                            rem_q      <= {WIDTH{1'b0}};
                            cnt_q      <= {CW{1'b0}};
                            busy_q     <= 1'b1;
                            state_q    <= ST_CALC;
                        end
                    end else begin
                        done_q <= 1'b0;
                    end
                end
                ST_CALC: begin
                    done_q <= 1'b0;
                    rem_q  <= rem_d;
                    quot_q <= quot_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= ST_FIX;
                    end else begin
                        state_q <= ST_CALC;
                    end
                end
                ST_FIX: begin
                    // Apply the signs with two's-complement wrap. This makes
                    // -2^(W-1) / -1 give -2^(W-1).
                    lo_q    <= sign_q_q ? ({WIDTH{1'b0}} - quot_q) : quot_q;
                    hi_q    <= sign_r_q ? ({WIDTH{1'b0}} - rem_q)  : rem_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider. The expected results come from plain
// 64-bit signed division, with a sticky model for hi/lo and div_zero.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_lo;
    logic [W-1:0] exp_hi;
    logic         exp_dz;

    seq_divider #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: signed division, truncated toward zero. A zero divisor keeps hi/lo.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, output int exp_edges);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == '0) begin
            exp_dz    = 1'b1;
            exp_edges = 0;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            exp_lo    = q[W-1:0];
            exp_hi    = r[W-1:0];
            exp_dz    = 1'b0;
            exp_edges = W + 1;
        end
    endtask

    // Issue one division and wait for done. If inj_at >= 0, a second start
    // with ia/ib is pulsed that many cycles after the first is accepted.
    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input int inj_at,
                       input logic [W-1:0] ia, input logic [W-1:0] ib, input string tag);
        int edges;
        int bcnt;
        int ee;
        model(a, b, ee);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        edges = 0;
        bcnt  = 0;
        while (!done && edges < 60) begin
            if (busy) bcnt++;
            if (edges == inj_at) begin
                start    = 1'b1;
                dividend = ia;
                divisor  = ib;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        chk({tag, " latency"}, 64'(edges), 64'(ee));
        chk({tag, " busy_cycles"}, 64'(bcnt), 64'(ee));
        chk({tag, " done"}, 64'(done), 64'(1));
        chk({tag, " lo"}, 64'(lo), 64'(exp_lo));
        chk({tag, " hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, " div_zero"}, 64'(div_zero), 64'(exp_dz));
        @(negedge clk);
        chk({tag, " done_pulse_width"}, 64'(done), 64'(0));
        chk({tag, " div_zero_sticky"}, 64'(div_zero), 64'(exp_dz));
    endtask

    initial begin
        int dcount;
        logic [W-1:0] a;
        logic [W-1:0] b;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        exp_lo   = '0;
        exp_hi   = '0;
        exp_dz   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst done", 64'(done), 64'(0));
        chk("rst dz", 64'(div_zero), 64'(0));
        chk("rst hi", 64'(hi), 64'(0));
        chk("rst lo", 64'(lo), 64'(0));
        reset = 1'b0;

        run(32'd7, 32'd2, -1, '0, '0, "7/2");
        run(-32'sd7, 32'd2, -1, '0, '0, "-7/2");
        run(32'd7, -32'sd2, -1, '0, '0, "7/-2");
        run(-32'sd7, -32'sd2, -1, '0, '0, "-7/-2");
        chk("lit -7/-2 hi", 64'(hi), 64'hFFFF_FFFF);
        run(32'd100, 32'd7, -1, '0, '0, "100/7");
        run(32'd5, 32'd0, -1, '0, '0, "5/0");
        chk("lit 5/0 lo", 64'(lo), 64'd14);
        chk("lit 5/0 hi", 64'(hi), 64'd2);
        run(32'd9, 32'd3, -1, '0, '0, "9/3");
        run(32'h8000_0000, 32'hFFFF_FFFF, -1, '0, '0, "ovf");
        chk("lit ovf lo", 64'(lo), 64'h8000_0000);
        run(32'd1000, 32'd10, 10, 32'd8, 32'd2, "restart");
        chk("lit restart lo", 64'(lo), 64'd100);
        run(32'd0, 32'd5, -1, '0, '0, "0/5");

        // Reset in the middle of a division: the operation is abandoned and no done follows.
        @(negedge clk);
        dividend = 32'd1000;
        divisor  = 32'd10;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        chk("midrst busy_before", 64'(busy), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst busy", 64'(busy), 64'(0));
        chk("midrst done", 64'(done), 64'(0));
        chk("midrst hi", 64'(hi), 64'(0));
        chk("midrst lo", 64'(lo), 64'(0));
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        chk("midrst no_done", 64'(dcount), 64'(0));
        exp_lo = '0;
        exp_hi = '0;
        exp_dz = 1'b0;
        run(32'd9, 32'd4, -1, '0, '0, "9/4");

        // Randomized operands, with corner values mixed in.
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            case ($urandom_range(0, 9))
                0:       b = '0;
                1:       b = ($urandom_range(0, 1) == 0) ? 32'd1 : 32'hFFFF_FFFF;
                2:       b = W'($urandom_range(1, 20));
                3:       b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 9) == 0) a = '0;
            run(a, b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1,
                $urandom, $urandom, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
